// File: rtl/issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_if
// Description : Bundle of all fetch, register-bank, CDB, reservation-station
//               and status signals of the in-order issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int REG_W  = 5,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 16
);
    // fetch side
    logic                       in_fetch_valid;
    logic                       out_fetch_next;
    logic [OP_W-1:0]            in_operator_type;
    logic [REG_W-1:0]           in_reg_1;
    logic [REG_W-1:0]           in_reg_2;
    logic [REG_W-1:0]           in_reg_3;
    // register bank read/rename
    logic [REG_W-1:0]           out_reg_1;
    logic [REG_W-1:0]           out_reg_2;
    logic [DATA_W-1:0]          in_val_1;
    logic [DATA_W-1:0]          in_val_2;
    logic [TAG_W-1:0]           in_tag_1;
    logic [TAG_W-1:0]           in_tag_2;
    logic                       out_bank_enable;
    logic [REG_W-1:0]           out_bank_reg;
    logic [TAG_W-1:0]           out_bank_tag;
    // common data bus
    logic                       in_CDB_broadcast;
    logic [TAG_W-1:0]           in_CDB_tag;
    logic [DATA_W-1:0]          in_CDB_val;
    // reservation station
    logic                       out_rs_enable;
    logic                       in_rs_ready;
    logic [TAG_W-1:0]           in_rs_tag;
    logic [OP_W-1:0]            out_operator_type;
    logic [DATA_W-1:0]          out_val_1;
    logic [DATA_W-1:0]          out_val_2;
    logic [TAG_W-1:0]           out_tag_1;
    logic [TAG_W-1:0]           out_tag_2;
    // control / status
    logic                       in_flush;
    logic [$clog2(DEPTH):0]     out_count;
    logic [CNT_W-1:0]           out_issue_count;

    // environment side (fetch, bank, CDB, RS)
    modport master (
        output in_fetch_valid, in_operator_type, in_reg_1, in_reg_2, in_reg_3,
        output in_val_1, in_val_2, in_tag_1, in_tag_2,
        output in_CDB_broadcast, in_CDB_tag, in_CDB_val,
        output in_rs_ready, in_rs_tag, in_flush,
        input  out_fetch_next, out_reg_1, out_reg_2,
        input  out_bank_enable, out_bank_reg, out_bank_tag,
        input  out_rs_enable, out_operator_type, out_val_1, out_val_2,
        input  out_tag_1, out_tag_2, out_count, out_issue_count
    );

    // issue queue side
    modport slave (
        input  in_fetch_valid, in_operator_type, in_reg_1, in_reg_2, in_reg_3,
        input  in_val_1, in_val_2, in_tag_1, in_tag_2,
        input  in_CDB_broadcast, in_CDB_tag, in_CDB_val,
        input  in_rs_ready, in_rs_tag, in_flush,
        output out_fetch_next, out_reg_1, out_reg_2,
        output out_bank_enable, out_bank_reg, out_bank_tag,
        output out_rs_enable, out_operator_type, out_val_1, out_val_2,
        output out_tag_1, out_tag_2, out_count, out_issue_count
    );
endinterface
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue
// Description : In-order instruction issue queue. Holds decoded instructions
//               in a circular buffer, reads head operands from the register
//               bank, forwards a same-cycle CDB result, and renames the head
//               destination to the accepting reservation-station tag.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int REG_W  = 5,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    issue_queue_if.slave  bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_occ_w = c_ptr_w + 1;
    // all-ones tag: operand value is present, no producer pending
    localparam logic [TAG_W-1:0] INVALID_TAG = '1;

    // entry storage; operands are fetched from the bank at the head instead
    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [REG_W-1:0]  reg1_q [DEPTH];
    logic [REG_W-1:0]  reg2_q [DEPTH];
    logic [REG_W-1:0]  reg3_q [DEPTH];

    logic [c_ptr_w-1:0] head_q, head_d;
    logic [c_ptr_w-1:0] tail_q, tail_d;
    logic [c_occ_w-1:0] count_q, count_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;

    logic w_full;
    logic w_ready;
    logic w_enq;
    logic w_valid;
    logic w_fire;
    logic w_fwd1;
    logic w_fwd2;

    // a full queue never accepts, even if the head issues this cycle
    assign w_full  = (count_q == c_occ_w'(DEPTH));
    assign w_ready = rst_n & ~bus.in_flush & ~w_full;
    assign w_enq   = bus.in_fetch_valid & w_ready;
    // rst_n gates the offer so a mid-operation reset silences it immediately
    assign w_valid = rst_n & ~bus.in_flush & (count_q != '0);
    assign w_fire  = w_valid & bus.in_rs_ready;

    // a waiting operand picks up a CDB result whose tag it is waiting for
    assign w_fwd1 = bus.in_CDB_broadcast & (bus.in_CDB_tag != INVALID_TAG) &
                    (bus.in_tag_1 != INVALID_TAG) & (bus.in_tag_1 == bus.in_CDB_tag);
    assign w_fwd2 = bus.in_CDB_broadcast & (bus.in_CDB_tag != INVALID_TAG) &
                    (bus.in_tag_2 != INVALID_TAG) & (bus.in_tag_2 == bus.in_CDB_tag);

    assign bus.out_fetch_next    = w_ready;
    assign bus.out_rs_enable     = w_valid;
    assign bus.out_reg_1         = reg1_q[head_q];
    assign bus.out_reg_2         = reg2_q[head_q];
    assign bus.out_operator_type = op_q[head_q];
    assign bus.out_val_1         = w_fwd1 ? bus.in_CDB_val : bus.in_val_1;
    assign bus.out_tag_1         = w_fwd1 ? INVALID_TAG    : bus.in_tag_1;
    assign bus.out_val_2         = w_fwd2 ? bus.in_CDB_val : bus.in_val_2;
    assign bus.out_tag_2         = w_fwd2 ? INVALID_TAG    : bus.in_tag_2;
    // rename lands in the bank at the same edge the head pops, so the
    // head itself still sees the old mapping and its successor the new one
    assign bus.out_bank_enable   = w_fire;
    assign bus.out_bank_reg      = reg3_q[head_q];
    assign bus.out_bank_tag      = bus.in_rs_tag;
    assign bus.out_count         = count_q;
    assign bus.out_issue_count   = issue_cnt_q;

    // pointer, occupancy and issue-counter next state
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        issue_cnt_d = issue_cnt_q;
        if (bus.in_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_enq) begin
                tail_d = tail_q + 1'b1;
            end
            if (w_fire) begin
                head_d      = head_q + 1'b1;
                issue_cnt_d = issue_cnt_q + 1'b1;
            end
            case ({w_enq, w_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            issue_cnt_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // entry write at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (w_enq) begin
            op_q[tail_q]   <= bus.in_operator_type;
            reg1_q[tail_q] <= bus.in_reg_1;
            reg2_q[tail_q] <= bus.in_reg_2;
            reg3_q[tail_q] <= bus.in_reg_3;
        end
    end
endmodule
`default_nettype wire

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, queue entries (power of two, >=2); DATA_W, default 32, operand width; TAG_W, default 5, tag width; REG_W, default 5, register index width; OP_W, default 5, operator width; CNT_W, default 16, issue-counter width.
REQ-002 SHALL define INVALID_TAG as all-ones TAG_W (5'b11111 at default), meaning "value present".
REQ-003 SHALL have ports:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  reset, synchronous, active-low
  in_fetch_valid  in  1  instruction offered by fetch
  out_fetch_next  out  1  queue can accept (ready)
  in_operator_type  in  OP_W  offered operator
  in_reg_1 / in_reg_2  in  REG_W  offered source registers
  in_reg_3  in  REG_W  offered destination register
  out_reg_1 / out_reg_2  out  REG_W  register-bank read addresses (head sources)
  in_val_1 / in_val_2  in  DATA_W  bank read values (combinational)
  in_tag_1 / in_tag_2  in  TAG_W  bank read tags (combinational)
  in_CDB_broadcast  in  1  CDB result valid this cycle
  in_CDB_tag  in  TAG_W  CDB producer tag
  in_CDB_val  in  DATA_W  CDB result
  out_rs_enable  out  1  head offered to reservation station (valid)
  in_rs_ready  in  1  reservation station has free slot
  in_rs_tag  in  TAG_W  tag of the slot that accepts
  out_operator_type  out  OP_W  head operator
  out_val_1 / out_val_2  out  DATA_W  head operands
  out_tag_1 / out_tag_2  out  TAG_W  head operand tags
  out_bank_enable  out  1  rename write strobe
  out_bank_reg  out  REG_W  register renamed
  out_bank_tag  out  TAG_W  new producer tag
  in_flush  in  1  discard all queued instructions
  out_count  out  clog2(DEPTH)+1  occupancy
  out_issue_count  out  CNT_W  instructions issued since reset

Function
REQ-004 SHALL store {operator, reg_1, reg_2, reg_3} per entry in a circular buffer with head/tail pointers wrapping modulo DEPTH; operands are NOT stored.
REQ-005 SHALL drive out_fetch_next = rst_n & ~in_flush & (out_count < DEPTH); enqueue = in_fetch_valid & out_fetch_next, entry written at next edge.
REQ-006 SHALL, when full, hold out_fetch_next=0 even if an issue occurs that cycle (no full-cycle pass-through).
REQ-007 SHALL drive out_reg_1/out_reg_2 from the head entry combinationally (don't-care when empty).
REQ-008 SHALL drive out_rs_enable = (out_count != 0) & ~in_flush; issue fires when out_rs_enable & in_rs_ready.
REQ-009 SHALL forward per operand: if in_CDB_broadcast, in_tag_n != INVALID_TAG and in_tag_n == in_CDB_tag, then out_val_n = in_CDB_val and out_tag_n = INVALID_TAG; otherwise out_val_n = in_val_n, out_tag_n = in_tag_n.
REQ-010 SHALL never forward when in_CDB_tag == INVALID_TAG.
REQ-011 SHALL drive out_bank_enable = issue fire (same cycle, combinational), out_bank_reg = head reg_3, out_bank_tag = in_rs_tag, so the bank updates at the same edge the head pops.
REQ-012 SHALL read sources before renaming: head with reg_1 == reg_3 receives the old mapping.
REQ-013 SHALL make a back-to-back dependent instruction (next head reads previous reg_3) see the new tag, the bank being written at the issue edge.
REQ-014 SHALL issue at most one instruction per cycle, strictly in program order; an instruction enqueued into an empty queue is offered no earlier than the following cycle.
REQ-015 SHALL support simultaneous enqueue and issue when not full: out_count unchanged.
REQ-016 SHALL hold head outputs stable while out_rs_enable=1 and in_rs_ready=0, except operand fields may change by REQ-009 forwarding.
REQ-017 SHALL on in_flush=1 set out_count=0 and head=tail=0 at next edge, discard any same-cycle enqueue, and suppress issue and out_bank_enable that cycle.
REQ-018 SHALL increment out_issue_count by 1 per issue fire, wrapping 2^CNT_W-1 -> 0; flush does not clear it.

Reset
REQ-019 SHALL, on rising clk with rst_n=0, clear head, tail, out_count and out_issue_count to 0; stored entry contents need not be cleared.
REQ-020 SHALL hold out_fetch_next, out_rs_enable and out_bank_enable at 0 while rst_n=0, including reset asserted mid-operation; queued instructions are lost.
REQ-021 SHALL accept enqueue in the first cycle after rst_n returns to 1.

Verification
REQ-022 Enqueue ADD r1,r2->r3; bank r1=(10,INVALID), r2=(20,INVALID); in_rs_ready=1, in_rs_tag=4 -> next cycle out_rs_enable=1, out_val_1=10, out_val_2=20; out_bank_enable=1, out_bank_reg=3, out_bank_tag=4; out_issue_count=1.
REQ-023 Head source tag 7, CDB broadcasts tag 7 value 99 same cycle -> out_val_1=99, out_tag_1=INVALID_TAG; CDB tag 31 -> no forwarding.
REQ-024 DEPTH=4, in_rs_ready=0, fetch 5 instructions -> out_count=4, out_fetch_next=0 on 5th offer; raise in_rs_ready -> in-order issue, pointers wrap, all 5 issued.
REQ-025 Back-to-back I0 r1->r5 (tag 2), I1 r5->r6 -> I1 reads bank tag 2 for r5 the cycle after I0 issues.
REQ-026 in_flush with 3 queued and in_fetch_valid=1 -> no issue, no bank write that cycle; out_count=0 next cycle; out_issue_count unchanged.
REQ-027 rst_n=0 for one edge with 2 queued -> out_count=0, out_rs_enable=0, out_issue_count=0; enqueue accepted the next cycle.
